// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler: global ghost-mode sequencer.
// Runs the level's scatter/chase phase schedule from a frame tick. Each power
// pellet overrides the schedule with frightened mode. Outputs a shared 2-bit
// mode, a one-cycle reverse pulse, a flash flag for the renderer and the
// current phase. All timing counts ticks, not clocks.
// Optional feature macro: FRIGHT_FLASH_EN builds the flash counter and drives
// fright_flash. When it is not defined, fright_flash is tied low.
// Interface: there is no valid/ready handshake. tick, start and power_pellet
// are one-cycle pulses and pause is a level. All are sampled on posedge clk,
// and every output is registered. An input sampled at edge N is visible
// after edge N.
module ghost_mode_scheduler #(
   parameter int TW            = 11,
   parameter int SCATTER_LONG  = 420,
   parameter int SCATTER_SHORT = 300,
   parameter int CHASE_LEN     = 1200,
   parameter int FRIGHT_LEN    = 360,
   parameter int FLASH_TICKS   = 120,
   parameter int FLASH_PERIOD  = 14
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       pause,
   input  logic       power_pellet,
   output logic [1:0] mode,
   output logic       reverse,
   output logic       fright_flash,
   output logic [2:0] phase,
   output logic       active,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SCHED  = 2'd1,
      S_FRIGHT = 2'd2
   } state_t;

   localparam logic [1:0]    MODE_SCATTER = 2'b00;
   localparam logic [1:0]    MODE_CHASE   = 2'b01;
   localparam logic [1:0]    MODE_FRIGHT  = 2'b10;
   localparam logic [TW-1:0] ONE          = TW'(1);

   // Every timing value must fit in a TW-bit timer without wrapping.
   if (SCATTER_LONG < 1 || SCATTER_LONG >= (1 << TW) ||
       SCATTER_SHORT < 1 || SCATTER_SHORT >= (1 << TW) ||
       CHASE_LEN < 1 || CHASE_LEN >= (1 << TW) ||
       FRIGHT_LEN < 1 || FRIGHT_LEN >= (1 << TW) ||
       FLASH_TICKS < 1 || FLASH_TICKS >= (1 << TW) ||
       FLASH_PERIOD < 1 || FLASH_PERIOD >= (1 << TW)) begin : g_bad_params
      $error("ghost_mode_scheduler: timing parameter outside 1..2**TW-1");
   end

   // Phase 7 is the endless chase. It never reloads, so its duration is unused.
   function automatic logic [TW-1:0] phase_dur(input logic [2:0] p);
      case (p)
         3'd0, 3'd2:       phase_dur = TW'(SCATTER_LONG);
         3'd1, 3'd3, 3'd5: phase_dur = TW'(CHASE_LEN);
         3'd4, 3'd6:       phase_dur = TW'(SCATTER_SHORT);
         default:          phase_dur = '0;
      endcase
   endfunction

   function automatic logic [1:0] sched_mode(input logic [2:0] p);
      sched_mode = p[0] ? MODE_CHASE : MODE_SCATTER;
   endfunction

   state_t        state, state_n;
   logic [TW-1:0] ptimer, ptimer_n;
   logic [TW-1:0] ftimer, ftimer_n;
   logic [2:0]    phase_n;
   logic [1:0]    mode_n;
   logic          reverse_n;
   logic          active_n;
   logic          enter_fright;
   logic          step;

   assign step      = tick && !pause;
   assign state_dbg = state;

   // State, phase and timer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         ptimer  <= '0;
         ftimer  <= '0;
         phase   <= 3'd0;
         mode    <= MODE_SCATTER;
         reverse <= 1'b0;
         active  <= 1'b0;
      end else begin
         state   <= state_n;
         ptimer  <= ptimer_n;
         ftimer  <= ftimer_n;
         phase   <= phase_n;
         mode    <= mode_n;
         reverse <= reverse_n;
         active  <= active_n;
      end
   end

   // Next-state logic. A pellet outranks a coincident tick, so the phase timer
   // is frozen on that cycle and any expiry waits until fright ends.
   always_comb begin
      state_n      = state;
      ptimer_n     = ptimer;
      ftimer_n     = ftimer;
      phase_n      = phase;
      mode_n       = mode;
      reverse_n    = 1'b0;
      active_n     = active;
      enter_fright = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n  = S_SCHED;
               phase_n  = 3'd0;
               ptimer_n = phase_dur(3'd0);
               mode_n   = MODE_SCATTER;
               active_n = 1'b1;
            end
         end
         S_SCHED: begin
            if (power_pellet) begin
               enter_fright = 1'b1;
            end else if (step && phase != 3'd7) begin
               if (ptimer == ONE) begin
                  phase_n   = phase + 3'd1;
                  ptimer_n  = phase_dur(phase + 3'd1);
                  mode_n    = sched_mode(phase + 3'd1);
                  reverse_n = 1'b1;
               end else begin
                  ptimer_n = ptimer - ONE;
               end
            end
         end
         S_FRIGHT: begin
            if (power_pellet) begin
               enter_fright = 1'b1;
            end else if (step) begin
               if (ftimer == ONE) begin
                  state_n  = S_SCHED;
                  ftimer_n = '0;
                  mode_n   = sched_mode(phase);
               end else begin
                  ftimer_n = ftimer - ONE;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (enter_fright) begin
         state_n   = S_FRIGHT;
         ftimer_n  = TW'(FRIGHT_LEN);
         mode_n    = MODE_FRIGHT;
         reverse_n = 1'b1;
      end
   end

`ifdef FRIGHT_FLASH_EN
   logic          flash_q, flash_n;
   logic [TW-1:0] fcnt, fcnt_n, fcnt_inc, ftimer_dec;
   logic          flash_clear;

   assign flash_clear  = (state != S_FRIGHT) || power_pellet || (step && ftimer == ONE);
   assign fcnt_inc     = fcnt + ONE;
   assign ftimer_dec   = ftimer - ONE;
   assign fright_flash = flash_q;

   // Flash registers. They hold while paused because only ticks advance them.
   always_ff @(posedge clk) begin
      if (rst) begin
         flash_q <= 1'b0;
         fcnt    <= '0;
      end else begin
         flash_q <= flash_n;
         fcnt    <= fcnt_n;
      end
   end

   // Flash turns on with the first tick that takes the fright timer into the
   // flash window. The first fright tick counts when FRIGHT_LEN already lies
   // inside that window. After that it toggles every FLASH_PERIOD ticks.
   always_comb begin
      flash_n = flash_q;
      fcnt_n  = fcnt;
      if (flash_clear) begin
         flash_n = 1'b0;
         fcnt_n  = '0;
      end else if (step && ftimer_dec <= TW'(FLASH_TICKS)) begin
         if (ftimer > TW'(FLASH_TICKS) || ftimer == TW'(FRIGHT_LEN)) begin
            flash_n = 1'b1;
            fcnt_n  = '0;
         end else if (fcnt_inc == TW'(FLASH_PERIOD)) begin
            flash_n = !flash_q;
            fcnt_n  = '0;
         end else begin
            fcnt_n = fcnt_inc;
         end
      end
   end
`else
   assign fright_flash = 1'b0;
`endif

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler. It uses the small test-plan timing values.
// Directed scenario tasks are followed by randomized traffic, which is checked
// against a tick-level reference model of the phase schedule.
module tb_ghost_mode_scheduler;
   localparam int TW = 11;
   localparam int SL = 4;
   localparam int SS = 3;
   localparam int CL = 5;
   localparam int FL = 6;
   localparam int FT = 4;
   localparam int FP = 2;
`ifdef FRIGHT_FLASH_EN
   localparam logic FLASH_EN = 1'b1;
`else
   localparam logic FLASH_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       power_pellet = 1'b0;
   logic [1:0] mode;
   logic       reverse;
   logic       fright_flash;
   logic [2:0] phase;
   logic       active;
   logic [1:0] state_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   int rev_seen = 0;
   logic [7:0] exp_q[$];

   // Reference model state: ticks left in the phase, and fright ticks elapsed.
   logic m_active = 1'b0;
   logic m_fright = 1'b0;
   logic m_rev    = 1'b0;
   int   m_phase  = 0;
   int   m_left   = 0;
   int   m_fe     = 0;
   int   dur [0:6] = '{SL, CL, SL, CL, SS, CL, SS};

   ghost_mode_scheduler #(
      .TW(TW), .SCATTER_LONG(SL), .SCATTER_SHORT(SS), .CHASE_LEN(CL),
      .FRIGHT_LEN(FL), .FLASH_TICKS(FT), .FLASH_PERIOD(FP)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
      .power_pellet(power_pellet), .mode(mode), .reverse(reverse),
      .fright_flash(fright_flash), .phase(phase), .active(active),
      .state_dbg(state_dbg)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Expected output vector {mode, reverse, flash, phase, active} from the model.
   function automatic logic [7:0] model_out();
      logic [1:0] m;
      logic       f;
      int         fs;
      fs = (FL > FT) ? FL - FT : 1;
      f  = FLASH_EN && m_fright && (m_fe >= fs) && ((((m_fe - fs) / FP) % 2) == 0);
      m  = m_fright ? 2'b10 : ((m_phase % 2 == 1) ? 2'b01 : 2'b00);
      return {m, m_rev, f, 3'(m_phase), m_active};
   endfunction

   // One clock: drive inputs, step the model with them, then sample the outputs 1 time unit after the edge.
   task automatic cyc(input logic t, input logic pp, input logic pa, input logic st, input logic r);
      tick = t; power_pellet = pp; pause = pa; start = st; rst = r;
      @(posedge clk);
      m_rev = 1'b0;
      if (r) begin
         m_active = 1'b0; m_fright = 1'b0; m_phase = 0; m_left = 0; m_fe = 0;
      end else if (!m_active) begin
         if (st) begin
            m_active = 1'b1; m_phase = 0; m_left = dur[0];
         end
      end else if (pp) begin
         m_fright = 1'b1; m_fe = 0; m_rev = 1'b1;
      end else if (t && !pa) begin
         if (m_fright) begin
            m_fe++;
            if (m_fe == FL) begin
               m_fright = 1'b0; m_fe = 0;
            end
         end else if (m_phase < 7) begin
            m_left--;
            if (m_left == 0) begin
               m_phase++;
               m_rev = 1'b1;
               if (m_phase < 7) m_left = dur[m_phase];
            end
         end
      end
      exp_q.push_back(model_out());
      #1;
      if (reverse === 1'b1) rev_seen++;
   endtask

   // n ticks, each one every 3 clocks, with pause held at pa.
   task automatic ticks(input int n, input logic pa);
      repeat (n) begin
         cyc(1'b0, 1'b0, pa, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, pa, 1'b0, 1'b0);
         cyc(1'b1, 1'b0, pa, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset();
      int r0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({mode, reverse, fright_flash, phase, active} !== 8'h00)
         $display("FAIL reset_outputs: got %b want 00000000", {mode, reverse, fright_flash, phase, active});
      else n_pass++;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({mode, reverse, active} !== 4'b0000)
         $display("FAIL idle_ignores_pellet: got %b want 0000", {mode, reverse, active});
      else n_pass++;
      r0 = rev_seen;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({active, mode, phase, reverse} !== 7'b1_00_000_0)
         $display("FAIL start_state: got %b want 1000000", {active, mode, phase, reverse});
      else n_pass++;
      ticks(2, 1'b0);
      n_checks++;
      if (rev_seen - r0 !== 0)
         $display("FAIL start_no_reverse: got %0d pulses want 0", rev_seen - r0);
      else n_pass++;
   endtask

   task automatic test_full_schedule();
      int exp_len [0:6] = '{4, 5, 4, 5, 3, 5, 3};
      int cnt, idx, r0;
      logic [1:0] prev;
      logic stuck_ok;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      r0 = rev_seen; cnt = 0; idx = 0; prev = mode;
      for (int k = 0; k < 29; k++) begin
         ticks(1, 1'b0);
         cnt++;
         if (mode !== prev) begin
            n_checks++;
            if (idx >= 7) $display("FAIL sched_len: extra mode change at tick %0d", k);
            else if (cnt !== exp_len[idx])
               $display("FAIL sched_len: phase %0d lasted %0d ticks want %0d", idx, cnt, exp_len[idx]);
            else n_pass++;
            n_checks++;
            if (int'(phase) !== idx + 1) $display("FAIL sched_phase: got %0d want %0d", phase, idx + 1);
            else n_pass++;
            idx++; cnt = 0; prev = mode;
         end
      end
      n_checks++;
      if (idx !== 7) $display("FAIL sched_changes: got %0d want 7", idx);
      else n_pass++;
      n_checks++;
      if (rev_seen - r0 !== 7) $display("FAIL sched_reverse_count: got %0d want 7", rev_seen - r0);
      else n_pass++;
      stuck_ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
         ticks(1, 1'b0);
         if (mode !== 2'b01 || phase !== 3'd7) stuck_ok = 1'b0;
      end
      n_checks++;
      if (!stuck_ok || rev_seen - r0 !== 7)
         $display("FAIL phase7_saturate: mode %b phase %0d reverses %0d want 01/7/7", mode, phase, rev_seen - r0);
      else n_pass++;
   endtask

   task automatic test_fright();
      logic exp_fl [1:6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic want_fl;
      logic [1:0] want_mode;
      int r0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(6, 1'b0);
      r0 = rev_seen;
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({mode, reverse, fright_flash} !== 4'b10_1_0)
         $display("FAIL fright_enter: got %b want 1010", {mode, reverse, fright_flash});
      else n_pass++;
      for (int k = 1; k <= 6; k++) begin
         ticks(1, 1'b0);
         want_fl   = FLASH_EN ? exp_fl[k] : 1'b0;
         want_mode = (k < 6) ? 2'b10 : 2'b01;
         n_checks++;
         if ({mode, fright_flash} !== {want_mode, want_fl})
            $display("FAIL fright_tick%0d: got %b want %b", k, {mode, fright_flash}, {want_mode, want_fl});
         else n_pass++;
      end
      n_checks++;
      if (rev_seen - r0 !== 1) $display("FAIL fright_reverse_count: got %0d want 1", rev_seen - r0);
      else n_pass++;
      ticks(2, 1'b0);
      n_checks++;
      if (phase !== 3'd1) $display("FAIL fright_phase_resume: got %0d want 1", phase);
      else n_pass++;
      ticks(1, 1'b0);
      n_checks++;
      if ({phase, mode} !== 5'b010_00) $display("FAIL fright_phase_expire: got %b want 01000", {phase, mode});
      else n_pass++;
   endtask

   task automatic test_collisions();
      int r0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(3, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({mode, phase, reverse} !== 6'b10_000_1)
         $display("FAIL pellet_vs_expiry: got %b want 100001", {mode, phase, reverse});
      else n_pass++;
      ticks(6, 1'b0);
      n_checks++;
      if ({mode, phase, reverse} !== 6'b00_000_0)
         $display("FAIL collide_fright_end: got %b want 000000", {mode, phase, reverse});
      else n_pass++;
      ticks(1, 1'b0);
      n_checks++;
      if ({mode, phase, reverse} !== 6'b01_001_1)
         $display("FAIL collide_deferred_expiry: got %b want 010011", {mode, phase, reverse});
      else n_pass++;
      r0 = rev_seen;
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(3, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(5, 1'b0);
      n_checks++;
      if (mode !== 2'b10) $display("FAIL repellet_still_fright: got %b want 10", mode);
      else n_pass++;
      ticks(1, 1'b0);
      n_checks++;
      if ({mode, phase} !== 5'b01_001) $display("FAIL repellet_exit: got %b want 01001", {mode, phase});
      else n_pass++;
      n_checks++;
      if (rev_seen - r0 !== 2) $display("FAIL repellet_reverse_count: got %0d want 2", rev_seen - r0);
      else n_pass++;
   endtask

   task automatic test_pause_and_reset();
      logic [5:0] snap;
      logic hold_ok;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(2, 1'b0);
      snap = {mode, fright_flash, phase};
      ticks(20, 1'b1);
      n_checks++;
      if ({mode, fright_flash, phase} !== snap)
         $display("FAIL pause_sched_hold: got %b want %b", {mode, fright_flash, phase}, snap);
      else n_pass++;
      ticks(1, 1'b0);
      n_checks++;
      if (phase !== 3'd0) $display("FAIL pause_timer_frozen: got %0d want 0", phase);
      else n_pass++;
      ticks(1, 1'b0);
      n_checks++;
      if (phase !== 3'd1) $display("FAIL pause_resume_expiry: got %0d want 1", phase);
      else n_pass++;
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ticks(2, 1'b0);
      hold_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         ticks(1, 1'b1);
         if (mode !== 2'b10 || fright_flash !== FLASH_EN || phase !== 3'd1) hold_ok = 1'b0;
      end
      n_checks++;
      if (!hold_ok) $display("FAIL pause_fright_hold: got %b want 10%b001", {mode, fright_flash, phase}, FLASH_EN);
      else n_pass++;
      ticks(1, 1'b0);
      n_checks++;
      if ({mode, fright_flash} !== {2'b10, FLASH_EN})
         $display("FAIL pause_flash_resume: got %b want 10%b", {mode, fright_flash}, FLASH_EN);
      else n_pass++;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({mode, active, fright_flash, phase, reverse} !== 8'h00)
         $display("FAIL late_reset: got %b want 00000000", {mode, active, fright_flash, phase, reverse});
      else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0] got, want;
      logic t, pp, pa, st, r;
      exp_q.delete();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      void'(exp_q.pop_front());
      for (int i = 0; i < 4000; i++) begin
         t  = ($urandom_range(0, 2) == 0);
         pp = ($urandom_range(0, 39) == 0);
         pa = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 29) == 0);
         r  = ($urandom_range(0, 1499) == 0);
         cyc(t, pp, pa, st, r);
         got = {mode, reverse, fright_flash, phase, active};
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL random_cycle%0d: expected queue empty, got %b", i, got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) $display("FAIL random_cycle%0d: got %b want %b", i, got, want);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_schedule();
      test_fright();
      test_collisions();
      test_pause_and_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
